// File: rtl/branch_resolver_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : branch_resolver_pkg
//  Brief   : Shared branch-op bit indices and resolver FSM state encoding.
//  Rev     : 1.0  initial release
// ============================================================================
package branch_resolver_pkg;

    localparam int c_BR_OP_W = 6;

    // One-hot bit positions inside br_op
    localparam int c_BR_BEQ  = 0;
    localparam int c_BR_BNE  = 1;
    localparam int c_BR_BLT  = 2;
    localparam int c_BR_BGE  = 3;
    localparam int c_BR_BLTU = 4;
    localparam int c_BR_BGEU = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
//  Module  : branch_resolver_if
//  Brief   : EX-stage branch inputs and flush/rollback/counter outputs.
//  Rev     : 1.0  initial release
// ============================================================================
interface branch_resolver_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 PL_stall;
    logic                 B_type_ex;
    logic [5:0]           br_op_ex;
    logic                 jalr_ex;
    logic [31:0]          pc_ex;
    logic [31:0]          imme_ex;
    logic [31:0]          rs1_data_ex;
    logic [31:0]          rs2_data_ex;
    logic                 prediction_ex;
    logic [31:0]          jalr_pc_prediction_ex;
    logic                 ras_push_id;
    logic                 ras_pop_id;

    logic                 PL_flush;
    logic [31:0]          redirect_pc;
    logic                 B_type_branch_failed;
    logic [5:0]           br_op_branch_failed;
    logic [31:0]          pc_branch_failed;
    logic                 B_type_result_branch_failed;
    logic                 ras_rollback_pop;
    logic                 ras_rollback_push;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispredict_cnt;

    modport master (
        output PL_stall, B_type_ex, br_op_ex, jalr_ex, pc_ex, imme_ex,
               rs1_data_ex, rs2_data_ex, prediction_ex, jalr_pc_prediction_ex,
               ras_push_id, ras_pop_id,
        input  PL_flush, redirect_pc, B_type_branch_failed, br_op_branch_failed,
               pc_branch_failed, B_type_result_branch_failed, ras_rollback_pop,
               ras_rollback_push, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  PL_stall, B_type_ex, br_op_ex, jalr_ex, pc_ex, imme_ex,
               rs1_data_ex, rs2_data_ex, prediction_ex, jalr_pc_prediction_ex,
               ras_push_id, ras_pop_id,
        output PL_flush, redirect_pc, B_type_branch_failed, br_op_branch_failed,
               pc_branch_failed, B_type_result_branch_failed, ras_rollback_pop,
               ras_rollback_push, branch_cnt, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolver_compare.sv
`default_nettype none
// ============================================================================
//  Module  : branch_compare
//  Brief   : Combinational B-type condition evaluation from a one-hot op.
//  Rev     : 1.0  initial release
// ============================================================================
module branch_compare
    import branch_resolver_pkg::*;
(
    input  wire logic [c_BR_OP_W-1:0] br_op,
    input  wire logic [31:0]          rs1,
    input  wire logic [31:0]          rs2,
    output logic                      taken
);
    logic                 w_eq;
    logic                 w_lt;
    logic                 w_ltu;
    logic [c_BR_OP_W-1:0] w_cond;

    assign w_eq  = (rs1 == rs2);
    assign w_lt  = ($signed(rs1) < $signed(rs2));
    assign w_ltu = (rs1 < rs2);

    always_comb begin
        w_cond            = '0;
        w_cond[c_BR_BEQ]  = w_eq;
        w_cond[c_BR_BNE]  = ~w_eq;
        w_cond[c_BR_BLT]  = w_lt;
        w_cond[c_BR_BGE]  = ~w_lt;
        w_cond[c_BR_BLTU] = w_ltu;
        w_cond[c_BR_BGEU] = ~w_ltu;
    end

    // An all-zero op selects nothing and therefore resolves not-taken
    assign taken = |(br_op & w_cond);

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module  : branch_resolver
//  Brief   : EX-stage branch/JALR resolution, flush + redirect, failed-branch
//            bundle, RAS rollback and saturating performance counters.
//  Rev     : 1.0  initial release
// ============================================================================
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int CNT_WIDTH = 32
)(
    input  wire logic         clk,
    input  wire logic         rst,
    branch_resolver_if.slave  bus
);
    state_t               r_state;
    logic [31:0]          r_redirect_pc;
    logic                 r_btype_failed;
    logic [5:0]           r_op_failed;
    logic [31:0]          r_pc_failed;
    logic                 r_result_failed;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    logic                 w_taken;
    logic [31:0]          w_b_target;
    logic [31:0]          w_j_target;
    logic                 w_mis_b;
    logic                 w_mis_j;

    branch_compare u_compare (
        .br_op (bus.br_op_ex),
        .rs1   (bus.rs1_data_ex),
        .rs2   (bus.rs2_data_ex),
        .taken (w_taken)
    );

    assign w_b_target = w_taken ? (bus.pc_ex + bus.imme_ex) : (bus.pc_ex + 32'd4);
    assign w_j_target = (bus.rs1_data_ex + bus.imme_ex) & 32'hFFFF_FFFE;
    assign w_mis_b    = bus.B_type_ex && (w_taken != bus.prediction_ex);
    assign w_mis_j    = bus.jalr_ex && (w_j_target != bus.jalr_pc_prediction_ex);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_redirect_pc    <= '0;
            r_btype_failed   <= 1'b0;
            r_op_failed      <= '0;
            r_pc_failed      <= '0;
            r_result_failed  <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.PL_stall) begin
                        if (bus.B_type_ex && !(&r_branch_cnt))
                            r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
                        if (w_mis_b && !(&r_mispredict_cnt))
                            r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
                        if (w_mis_b || w_mis_j) begin
                            r_state         <= FLUSH;
                            r_redirect_pc   <= w_mis_b ? w_b_target : w_j_target;
                            r_pc_failed     <= bus.pc_ex;
                            r_btype_failed  <= w_mis_b;
                            r_op_failed     <= w_mis_b ? bus.br_op_ex : 6'b0;
                            r_result_failed <= w_mis_b & w_taken;
                        end
                    end
                end
                // EX holds wrong-path work here, so nothing is detected or counted
                FLUSH: begin
                    r_state         <= IDLE;
                    r_btype_failed  <= 1'b0;
                    r_op_failed     <= '0;
                    r_result_failed <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.PL_flush                    = (r_state == FLUSH);
    assign bus.redirect_pc                 = r_redirect_pc;
    assign bus.B_type_branch_failed        = r_btype_failed;
    assign bus.br_op_branch_failed         = r_op_failed;
    assign bus.pc_branch_failed            = r_pc_failed;
    assign bus.B_type_result_branch_failed = r_result_failed;
    assign bus.ras_rollback_pop            = (r_state == FLUSH) && bus.ras_push_id;
    assign bus.ras_rollback_push           = (r_state == FLUSH) && bus.ras_pop_id;
    assign bus.branch_cnt                  = r_branch_cnt;
    assign bus.mispredict_cnt              = r_mispredict_cnt;

    a_br_op_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.br_op_ex));
    a_btype_jalr_excl : assert property (@(posedge clk) disable iff (rst)
        !(bus.B_type_ex && bus.jalr_ex));

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_branch_resolver
//  Brief   : Directed self-checking bench for branch_resolver (4-bit counters).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_branch_resolver;
    localparam int CNT_WIDTH = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [CNT_WIDTH-1:0] exp_b;
    logic [CNT_WIDTH-1:0] exp_m;

    branch_resolver_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    branch_resolver #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.PL_stall              = 1'b0;
        bus.B_type_ex             = 1'b0;
        bus.br_op_ex              = 6'b0;
        bus.jalr_ex               = 1'b0;
        bus.pc_ex                 = 32'h0;
        bus.imme_ex               = 32'h0;
        bus.rs1_data_ex           = 32'h0;
        bus.rs2_data_ex           = 32'h0;
        bus.prediction_ex         = 1'b0;
        bus.jalr_pc_prediction_ex = 32'h0;
        bus.ras_push_id           = 1'b0;
        bus.ras_pop_id            = 1'b0;
    endtask

    task automatic drive_branch(input logic [5:0] op, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic pred,
                                input logic [31:0] pc, input logic [31:0] imm);
        drive_idle();
        bus.B_type_ex     = 1'b1;
        bus.br_op_ex      = op;
        bus.rs1_data_ex   = rs1;
        bus.rs2_data_ex   = rs2;
        bus.prediction_ex = pred;
        bus.pc_ex         = pc;
        bus.imme_ex       = imm;
    endtask

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed, bus.br_op_branch_failed,
             bus.pc_branch_failed, bus.B_type_result_branch_failed, bus.ras_rollback_pop,
             bus.ras_rollback_push, bus.branch_cnt, bus.mispredict_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: flush=%b redir=%h bcnt=%h mcnt=%h, all required 0",
                     bus.PL_flush, bus.redirect_pc, bus.branch_cnt, bus.mispredict_cnt);
        end
        rst = 1'b0;
        exp_b = '0;
        exp_m = '0;
    endtask

    task automatic test_beq();
        drive_branch(6'b000001, 32'd5, 32'd5, 1'b0, 32'h100, 32'h20);
        exp_b = sat_inc(exp_b);
        exp_m = sat_inc(exp_m);
        tick();
        drive_idle();
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed, bus.br_op_branch_failed,
             bus.B_type_result_branch_failed, bus.pc_branch_failed} !==
            {1'b1, 32'h120, 1'b1, 6'b000001, 1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL beq_flush: flush=%b redir=%h bt=%b op=%b res=%b pc=%h, required 1 120 1 000001 1 100",
                     bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed,
                     bus.br_op_branch_failed, bus.B_type_result_branch_failed, bus.pc_branch_failed);
        end
        n_vec++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {exp_b, exp_m}) begin
            n_err++;
            $display("FAIL beq_counters: b=%0d m=%0d, required b=%0d m=%0d",
                     bus.branch_cnt, bus.mispredict_cnt, exp_b, exp_m);
        end
        tick();
        n_vec++;
        if ({bus.PL_flush, bus.B_type_branch_failed, bus.br_op_branch_failed,
             bus.B_type_result_branch_failed, bus.redirect_pc, bus.pc_branch_failed} !==
            {1'b0, 1'b0, 6'b0, 1'b0, 32'h120, 32'h100}) begin
            n_err++;
            $display("FAIL beq_after_flush: flush=%b bt=%b op=%b res=%b redir=%h pc=%h, required 0 0 0 0 120 100",
                     bus.PL_flush, bus.B_type_branch_failed, bus.br_op_branch_failed,
                     bus.B_type_result_branch_failed, bus.redirect_pc, bus.pc_branch_failed);
        end
    endtask

    task automatic test_signed_unsigned();
        drive_branch(6'b000100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h200, 32'h40);
        exp_b = sat_inc(exp_b);
        tick();
        n_vec++;
        if (bus.PL_flush !== 1'b0) begin
            n_err++;
            $display("FAIL blt_signed_no_flush: flush=%b, required 0", bus.PL_flush);
        end
        drive_branch(6'b010000, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h200, 32'h40);
        exp_b = sat_inc(exp_b);
        exp_m = sat_inc(exp_m);
        tick();
        drive_idle();
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.B_type_result_branch_failed, bus.br_op_branch_failed} !==
            {1'b1, 32'h204, 1'b0, 6'b010000}) begin
            n_err++;
            $display("FAIL bltu_flush: flush=%b redir=%h res=%b op=%b, required 1 204 0 010000",
                     bus.PL_flush, bus.redirect_pc, bus.B_type_result_branch_failed,
                     bus.br_op_branch_failed);
        end
        n_vec++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {exp_b, exp_m}) begin
            n_err++;
            $display("FAIL bltu_counters: b=%0d m=%0d, required b=%0d m=%0d",
                     bus.branch_cnt, bus.mispredict_cnt, exp_b, exp_m);
        end
        tick();
    endtask

    task automatic test_jalr();
        drive_idle();
        bus.ras_push_id = 1'b1;
        #1;
        n_vec++;
        if (bus.ras_rollback_pop !== 1'b0) begin
            n_err++;
            $display("FAIL ras_idle: rollback_pop=%b, required 0", bus.ras_rollback_pop);
        end
        drive_idle();
        bus.jalr_ex               = 1'b1;
        bus.rs1_data_ex           = 32'h203;
        bus.imme_ex               = 32'h0;
        bus.pc_ex                 = 32'h180;
        bus.jalr_pc_prediction_ex = 32'h300;
        tick();
        drive_idle();
        bus.ras_push_id = 1'b1;
        #1;
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed, bus.br_op_branch_failed,
             bus.pc_branch_failed, bus.ras_rollback_pop, bus.ras_rollback_push} !==
            {1'b1, 32'h202, 1'b0, 6'b0, 32'h180, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL jalr_flush: flush=%b redir=%h bt=%b op=%b pc=%h rpop=%b rpush=%b, required 1 202 0 0 180 1 0",
                     bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed, bus.br_op_branch_failed,
                     bus.pc_branch_failed, bus.ras_rollback_pop, bus.ras_rollback_push);
        end
        n_vec++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {exp_b, exp_m}) begin
            n_err++;
            $display("FAIL jalr_counters: b=%0d m=%0d, required b=%0d m=%0d",
                     bus.branch_cnt, bus.mispredict_cnt, exp_b, exp_m);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_stall();
        drive_branch(6'b000010, 32'd7, 32'd7, 1'b1, 32'h300, 32'h8);
        bus.PL_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({bus.PL_flush, bus.branch_cnt, bus.mispredict_cnt} !== {1'b0, exp_b, exp_m}) begin
                n_err++;
                $display("FAIL stall_hold_%0d: flush=%b b=%0d m=%0d, required 0 %0d %0d",
                         i, bus.PL_flush, bus.branch_cnt, bus.mispredict_cnt, exp_b, exp_m);
            end
        end
        bus.PL_stall = 1'b0;
        exp_b = sat_inc(exp_b);
        exp_m = sat_inc(exp_m);
        tick();
        drive_idle();
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.mispredict_cnt, bus.branch_cnt} !==
            {1'b1, 32'h304, exp_m, exp_b}) begin
            n_err++;
            $display("FAIL stall_release: flush=%b redir=%h m=%0d b=%0d, required 1 304 %0d %0d",
                     bus.PL_flush, bus.redirect_pc, bus.mispredict_cnt, bus.branch_cnt, exp_m, exp_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_branch(6'b001000, 32'd9, 32'd3, 1'b0, 32'h500, 32'h30);
        exp_b = sat_inc(exp_b);
        exp_m = sat_inc(exp_m);
        tick();
        // Second mispredict arrives in the flush cycle and also under stall
        drive_branch(6'b000001, 32'd1, 32'd1, 1'b0, 32'h600, 32'h10);
        bus.PL_stall = 1'b1;
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc} !== {1'b1, 32'h530}) begin
            n_err++;
            $display("FAIL b2b_first_flush: flush=%b redir=%h, required 1 530",
                     bus.PL_flush, bus.redirect_pc);
        end
        tick();
        drive_idle();
        n_vec++;
        if ({bus.PL_flush, bus.branch_cnt, bus.mispredict_cnt, bus.redirect_pc} !==
            {1'b0, exp_b, exp_m, 32'h530}) begin
            n_err++;
            $display("FAIL b2b_wrong_path: flush=%b b=%0d m=%0d redir=%h, required 0 %0d %0d 530",
                     bus.PL_flush, bus.branch_cnt, bus.mispredict_cnt, bus.redirect_pc, exp_b, exp_m);
        end
        tick();
    endtask

    task automatic test_saturate_and_reset();
        for (int i = 0; i < 20 && exp_m != 4'hE; i++) begin
            drive_branch(6'b000001, 32'd2, 32'd2, 1'b0, 32'h400, 32'h10);
            exp_b = sat_inc(exp_b);
            exp_m = sat_inc(exp_m);
            tick();
            drive_idle();
            tick();
        end
        n_vec++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {exp_b, 4'hE}) begin
            n_err++;
            $display("FAIL sat_preload: b=%0d m=%0d, required b=%0d m=14",
                     bus.branch_cnt, bus.mispredict_cnt, exp_b);
        end
        for (int i = 0; i < 2; i++) begin
            drive_branch(6'b000001, 32'd2, 32'd2, 1'b0, 32'h400, 32'h10);
            tick();
            drive_idle();
            tick();
        end
        n_vec++;
        if ({bus.branch_cnt, bus.mispredict_cnt} !== {4'hF, 4'hF}) begin
            n_err++;
            $display("FAIL sat_allones: b=%0d m=%0d, required 15 15",
                     bus.branch_cnt, bus.mispredict_cnt);
        end
        drive_branch(6'b100000, 32'd1, 32'd2, 1'b1, 32'h700, 32'h44);
        tick();
        drive_idle();
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc} !== {1'b1, 32'h704}) begin
            n_err++;
            $display("FAIL bgeu_flush: flush=%b redir=%h, required 1 704",
                     bus.PL_flush, bus.redirect_pc);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.PL_flush, bus.redirect_pc, bus.B_type_branch_failed, bus.br_op_branch_failed,
             bus.pc_branch_failed, bus.B_type_result_branch_failed, bus.branch_cnt,
             bus.mispredict_cnt} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_flush: flush=%b redir=%h pc=%h b=%0d m=%0d, required all 0",
                     bus.PL_flush, bus.redirect_pc, bus.pc_branch_failed,
                     bus.branch_cnt, bus.mispredict_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive_idle();
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jalr();
        test_stall();
        test_back_to_back();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
